// File: rtl/led_pattern_gen.sv
// led_pattern_gen: N_CH-channel LED driver with OFF / ON / BLINK / BREATHE modes and shared PWM.
// Define LED_BREATHE_EN to build BREATHE mode; without it mode 3 behaves exactly as OFF.
module led_pattern_gen #(
  parameter int CLK_HZ     = 25000000,
  parameter int TICK_HZ    = 1000,
  parameter int N_CH       = 4,
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 1,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [15:0]         cfg_half,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [N_CH-1:0]     led,
  output logic                tick
);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(DIV - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [N_CH-1:0]     led_q, led_d;
  logic [N_CH-1:0]     lit_w;
  logic                tick_w;
  logic                wr_en;

  assign tick_w = (pre_q == PRE_TERM);
  assign pre_d  = tick_w ? '0 : pre_q + PRE_W'(1);
  assign pwm_d  = pwm_q + PWM_BITS'(1);
  assign wr_en  = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(N_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      pwm_q <= '0;
    end else begin
      pre_q <= pre_d;
      pwm_q <= pwm_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [1:0]          mode_q;
    logic [15:0]         half_q;
    logic [15:0]         phase_q;
    logic [15:0]         half_m1;
    logic [PWM_BITS-1:0] duty_q;
    logic                state_q;
    logic                wr;
    logic                stepping;
    logic                wrap;
    logic                lit;

    // A write to this channel takes priority over a coincident tick.
    assign wr      = wr_en && (cfg_ch == CH_W'(g));
    assign half_m1 = (half_q == 16'd0) ? 16'd0 : half_q - 16'd1;
    assign wrap    = (phase_q == half_m1);

`ifdef LED_BREATHE_EN
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_up;
    logic                dir_q;

    assign stepping = tick_w && ((mode_q == MODE_BLINK) || (mode_q == MODE_BREATHE));
    assign level_up = level_q + PWM_BITS'(1);

    // Triangle between 0 and duty; dir_q = 0 means rising.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q <= '0;
        dir_q   <= 1'b0;
      end else if (wr) begin
        level_q <= '0;
        dir_q   <= 1'b0;
      end else if (stepping && wrap && (mode_q == MODE_BREATHE)) begin
        if (!dir_q) begin
          if (level_q < duty_q) begin
            level_q <= level_up;
            if (level_up == duty_q) dir_q <= 1'b1;
          end
        end else if (level_q != '0) begin
          level_q <= level_q - PWM_BITS'(1);
          if (level_q == PWM_BITS'(1)) dir_q <= 1'b0;
        end
      end
    end
`else
    assign stepping = tick_w && (mode_q == MODE_BLINK);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q  <= MODE_OFF;
        half_q  <= '0;
        duty_q  <= '0;
        phase_q <= '0;
        state_q <= 1'b0;
      end else if (wr) begin
        mode_q  <= cfg_mode;
        half_q  <= cfg_half;
        duty_q  <= cfg_duty;
        phase_q <= '0;
        state_q <= 1'b0;
      end else if (stepping) begin
        if (wrap) begin
          phase_q <= '0;
          if (mode_q == MODE_BLINK) state_q <= ~state_q;
        end else begin
          phase_q <= phase_q + 16'd1;
        end
      end
    end

    always_comb begin
      lit = 1'b0;
      case (mode_q)
        MODE_ON:      lit = (pwm_q < duty_q);
        MODE_BLINK:   lit = state_q && (pwm_q < duty_q);
`ifdef LED_BREATHE_EN
        MODE_BREATHE: lit = (pwm_q < level_q);
`endif
        default:      lit = 1'b0;
      endcase
    end

    assign lit_w[g] = lit;
  end

  assign led_d = lit_w ^ {N_CH{POL}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= {N_CH{POL}};
    end else begin
      led_q <= led_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_w;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: compares led/tick every cycle against a
// tick-count model (blink state and breathe level derived from ticks since the last write).
`timescale 1ns/1ps
module tb_led_pattern_gen;

  localparam int NCH = 4;
  localparam int DIV = 10;
  localparam int PWM_N = 16;
`ifdef LED_BREATHE_EN
  localparam bit BREATHE = 1'b1;
`else
  localparam bit BREATHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_half;
  logic [3:0]  cfg_duty;
  logic [3:0]  led;
  logic        tick;

  logic        cfg5_we;
  logic [2:0]  cfg5_ch;
  logic [1:0]  cfg5_mode;
  logic [15:0] cfg5_half;
  logic [3:0]  cfg5_duty;
  logic [4:0]  led5;
  logic        tick5;

  int nChecks = 0;
  int nFail   = 0;

  int   mCyc;
  int   mMode[NCH];
  int   mHalf[NCH];
  int   mDuty[NCH];
  int   mTicks[NCH];
  logic [3:0] expLed;
  logic       expTick;

  led_pattern_gen #(.CLK_HZ(1000), .TICK_HZ(100), .N_CH(4), .PWM_BITS(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_duty(cfg_duty), .led(led), .tick(tick)
  );

  led_pattern_gen #(.CLK_HZ(1000), .TICK_HZ(100), .N_CH(5), .PWM_BITS(4), .ACTIVE_LOW(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg5_we), .cfg_ch(cfg5_ch), .cfg_mode(cfg5_mode),
    .cfg_half(cfg5_half), .cfg_duty(cfg5_duty), .led(led5), .tick(tick5)
  );

  always #5 clk = ~clk;

  function automatic int breatheLevel(int t, int h, int d);
    int s;
    int p;
    if (d == 0) return 0;
    s = t / h;
    p = s % (2 * d);
    return (p <= d) ? p : 2 * d - p;
  endfunction

  function automatic logic modelLit(int ch, int pwm);
    case (mMode[ch])
      1:       return pwm < mDuty[ch];
      2:       return ((mTicks[ch] / mHalf[ch]) % 2 == 1) && (pwm < mDuty[ch]);
      3:       return BREATHE && (pwm < breatheLevel(mTicks[ch], mHalf[ch], mDuty[ch]));
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    mCyc = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      mMode[ch] = 0; mHalf[ch] = 1; mDuty[ch] = 0; mTicks[ch] = 0;
    end
    expLed  = 4'hF;
    expTick = 1'b0;
  endtask

  // One clock edge of the model: led from the pre-edge configuration, then writes and ticks.
  task automatic modelEdge();
    logic [3:0] lit;
    bit tickNow;
    tickNow = (mCyc % DIV) == DIV - 1;
    for (int ch = 0; ch < NCH; ch++) lit[ch] = modelLit(ch, mCyc % PWM_N);
    expLed = ~lit;
    for (int ch = 0; ch < NCH; ch++) begin
      if (cfg_we && int'(cfg_ch) == ch) begin
        mMode[ch]  = int'(cfg_mode);
        mHalf[ch]  = (cfg_half == 16'd0) ? 1 : int'(cfg_half);
        mDuty[ch]  = int'(cfg_duty);
        mTicks[ch] = 0;
      end else if (tickNow && (mMode[ch] == 2 || (BREATHE && mMode[ch] == 3))) begin
        mTicks[ch]++;
      end
    end
    mCyc++;
    expTick = (mCyc % DIV) == DIV - 1;
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    cfg_we  = 1'b0;
    cfg5_we = 1'b0;
  endtask

  task automatic write(input int ch, input int mode, input int half, input int duty);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_mode = 2'(mode);
    cfg_half = 16'(half);
    cfg_duty = 4'(duty);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half = '0; cfg_duty = '0;
    cfg5_we = 1'b0; cfg5_ch = '0; cfg5_mode = '0; cfg5_half = '0; cfg5_duty = '0;
    #12;
    nChecks++;
    if (led !== 4'hF) begin nFail++; $display("[TB] FAIL reset_led got=%b exp=1111", led); end
    nChecks++;
    if (tick !== 1'b0) begin nFail++; $display("[TB] FAIL reset_tick got=%b exp=0", tick); end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    for (int i = 1; i <= DIV; i++) begin
      step();
      nChecks++;
      if (tick !== (i == DIV - 1)) begin
        nFail++; $display("[TB] FAIL first_tick i=%0d got=%b exp=%b", i, tick, (i == DIV - 1));
      end
      nChecks++;
      if (led !== 4'hF) begin nFail++; $display("[TB] FAIL idle_led i=%0d got=%b exp=1111", i, led); end
    end
  endtask

  task automatic test_blink();
    write(0, 2, 3, 15);
    for (int i = 0; i < 130; i++) begin
      step();
      nChecks++;
      if (led !== expLed) begin nFail++; $display("[TB] FAIL blink_h3 cyc=%0d got=%b exp=%b", mCyc, led, expLed); end
    end
    write(0, 2, 0, 15);
    for (int i = 0; i < 60; i++) begin
      step();
      nChecks++;
      if (led !== expLed) begin nFail++; $display("[TB] FAIL blink_h0 cyc=%0d got=%b exp=%b", mCyc, led, expLed); end
    end
    write(0, 0, 0, 0);
    step();
  endtask

  task automatic test_on_sweep();
    int dark;
    int duties[3];
    duties[0] = 0; duties[1] = 8; duties[2] = 15;
    for (int d = 0; d < 3; d++) begin
      write(1, 1, 0, duties[d]);
      step();
      dark = 0;
      for (int i = 0; i < PWM_N; i++) begin
        step();
        if (led[1] === 1'b0) dark++;
        nChecks++;
        if (led !== expLed) begin nFail++; $display("[TB] FAIL on_led cyc=%0d got=%b exp=%b", mCyc, led, expLed); end
      end
      nChecks++;
      if (dark != duties[d]) begin nFail++; $display("[TB] FAIL on_duty_count got=%0d exp=%0d", dark, duties[d]); end
    end
    write(1, 0, 0, 15);
    step();
    for (int i = 0; i < PWM_N; i++) begin
      step();
      nChecks++;
      if (led[1] !== 1'b1) begin nFail++; $display("[TB] FAIL off_led1 cyc=%0d got=%b exp=1", mCyc, led[1]); end
    end
  endtask

  task automatic test_breathe();
    write(2, 3, 1, 3);
    for (int i = 0; i < 160; i++) begin
      step();
      nChecks++;
      if (led !== expLed) begin nFail++; $display("[TB] FAIL breathe cyc=%0d got=%b exp=%b", mCyc, led, expLed); end
    end
    write(2, 0, 0, 0);
    step();
  endtask

  task automatic test_collision();
    write(0, 2, 1, 15);
    step();
    write(3, 2, 1, 15);
    step();
    for (int i = 0; i < DIV && !expTick; i++) step();
    nChecks++;
    if (tick !== 1'b1) begin nFail++; $display("[TB] FAIL collide_tick got=%b exp=1", tick); end
    write(3, 2, 1, 15);
    for (int i = 0; i < 60; i++) begin
      step();
      nChecks++;
      if (led !== expLed) begin nFail++; $display("[TB] FAIL collide cyc=%0d got=%b exp=%b", mCyc, led, expLed); end
    end
  endtask

  task automatic test_out_of_range();
    int dark;
    for (int c = 5; c <= 7; c++) begin
      cfg5_we = 1'b1; cfg5_ch = 3'(c); cfg5_mode = 2'd1; cfg5_half = 16'd1; cfg5_duty = 4'd15;
      step();
    end
    for (int i = 0; i < 20; i++) begin
      step();
      nChecks++;
      if (led5 !== 5'h1F) begin nFail++; $display("[TB] FAIL oor_ignored got=%b exp=11111", led5); end
    end
    cfg5_we = 1'b1; cfg5_ch = 3'd4; cfg5_mode = 2'd1; cfg5_half = 16'd1; cfg5_duty = 4'd15;
    step();
    dark = 0;
    for (int i = 0; i < PWM_N; i++) begin
      step();
      if (led5[4] === 1'b0) dark++;
      nChecks++;
      if (led5[3:0] !== 4'hF) begin nFail++; $display("[TB] FAIL ch4_others got=%b exp=1111", led5[3:0]); end
    end
    nChecks++;
    if (dark != 15) begin nFail++; $display("[TB] FAIL ch4_on_count got=%0d exp=15", dark); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0)
        write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
      step();
      nChecks++;
      if (led !== expLed) begin nFail++; $display("[TB] FAIL random_led cyc=%0d got=%b exp=%b", mCyc, led, expLed); end
      nChecks++;
      if (tick !== expTick) begin nFail++; $display("[TB] FAIL random_tick cyc=%0d got=%b exp=%b", mCyc, tick, expTick); end
    end
  endtask

  task automatic test_midreset();
    write(0, 2, 1, 15);
    write(0, 2, 1, 15);
    step();
    for (int i = 0; i < 15; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (led !== 4'hF) begin nFail++; $display("[TB] FAIL midreset_led got=%b exp=1111", led); end
    nChecks++;
    if (tick !== 1'b0) begin nFail++; $display("[TB] FAIL midreset_tick got=%b exp=0", tick); end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    for (int i = 1; i <= DIV + 2; i++) begin
      step();
      nChecks++;
      if (tick !== (i == DIV - 1)) begin nFail++; $display("[TB] FAIL rerelease_tick i=%0d got=%b", i, tick); end
      nChecks++;
      if (led !== 4'hF) begin nFail++; $display("[TB] FAIL rerelease_led i=%0d got=%b exp=1111", i, led); end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_on_sweep();
    test_breathe();
    test_collision();
    test_out_of_range();
    test_random();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
